seg7_scan_driver: RTL and testbench

- Consumes the 16-bit four-nibble `display` bus produced by the scrolling-digit stage.
- Drives the board's 4-digit common-anode seven-segment display by time-multiplexing one digit at a time.
- Captures `display` once per full scan frame so all four digits in a frame come from the same value (no tearing).
- Decodes each nibble to segment patterns and signals each frame capture to upstream with a one-cycle pulse.

---
 rtl/seg7_scan_driver.sv | 105 ++++++++++
 tb/tb_seg7_scan_driver.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// Optional leading-zero suppression when SEG7_LEADING_ZERO_BLANK_EN is defined.
module seg7_scan_driver #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] display,
  input  logic [3:0]  dp_mask,
  input  logic        blank,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);
  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [CNT_W-1:0] div_cnt;
  logic [1:0]       idx;
  logic [15:0]      snap;
  logic [3:0]       snap_dp;
  logic             loaded;
  logic [1:0]       ld_pipe;
  logic             tick, load, digit_on;
  logic [1:0]       pos;
  logic [3:0]       nib;
  logic [6:0]       seg_d;

  assign tick = (div_cnt == CNT_W'(REFRESH_DIV - 1));
  assign load = !loaded || (tick && idx == 2'd3);
  // idx counts left to right; pos is the bit position within snap/an
  assign pos  = 2'd3 - idx;
  assign nib  = snap[{pos, 2'b00} +: 4];

  always_comb begin
    seg_d = 7'b1111111;
    case (nib)
      4'h0: seg_d = 7'b1000000;
      4'h1: seg_d = 7'b1111001;
      4'h2: seg_d = 7'b0100100;
      4'h3: seg_d = 7'b0110000;
      4'h4: seg_d = 7'b0011001;
      4'h5: seg_d = 7'b0010010;
      4'h6: seg_d = 7'b0000010;
      4'h7: seg_d = 7'b1111000;
      4'h8: seg_d = 7'b0000000;
      4'h9: seg_d = 7'b0010000;
      4'hA: seg_d = 7'b0001000;
      4'hB: seg_d = 7'b0000011;
      4'hC: seg_d = 7'b1000110;
      4'hD: seg_d = 7'b0100001;
      4'hE: seg_d = 7'b0000110;
      4'hF: seg_d = 7'b0001110;
      default: seg_d = 7'b1111111;
    endcase
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  // A digit stays dark while it and every digit to its left are zero
  always_comb begin
    digit_on = 1'b1;
    case (idx)
      2'd0: digit_on = (snap[15:12] != 4'h0);
      2'd1: digit_on = (snap[15:8]  != 8'h00);
      2'd2: digit_on = (snap[15:4]  != 12'h000);
      default: digit_on = 1'b1;
    endcase
  end
`else
  assign digit_on = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      idx     <= 2'd0;
      snap    <= 16'h0000;
      snap_dp <= 4'h0;
      loaded  <= 1'b0;
      ld_pipe <= 2'b00;
      an      <= 4'b1111;
      seg     <= 7'b1111111;
      dp      <= 1'b1;
    end else begin
      if (tick) begin
        div_cnt <= '0;
        idx     <= idx + 2'd1;
      end else begin
        div_cnt <= div_cnt + CNT_W'(1);
      end
      if (load) begin
        snap    <= display;
        snap_dp <= dp_mask;
        loaded  <= 1'b1;
      end
      // frame_done lines up with the first displayed slot of the new frame
      ld_pipe <= {ld_pipe[0], load};
      an      <= (!loaded || blank || !digit_on) ? 4'b1111 : ~(4'b0001 << pos);
      seg     <= seg_d;
      dp      <= ~snap_dp[pos];
    end
  end

  assign frame_done = ld_pipe[1];
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: count-based reference model plus directed checks.
module tb_seg7_scan_driver;
  localparam int R = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] display;
  logic [3:0]  dp_mask;
  logic        blank;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  seg7_scan_driver #(.REFRESH_DIV(R)) dut (
    .clk(clk), .rst(rst), .display(display), .dp_mask(dp_mask), .blank(blank),
    .an(an), .seg(seg), .dp(dp), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] DEC [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  int nchk = 0;
  int nfail = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Model: n counts edges since reset release; slot and frame follow from n.
  int          n;
  logic [15:0] m_snap;
  logic [3:0]  m_dpm;
  logic        m_ld;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp, e_fd, m_on, mvalid = 1'b0;
  int          d;
  logic [15:0] pre;

  always @(posedge clk) begin
    if (rst) begin
      n = 0; m_snap = 16'h0; m_dpm = 4'h0; m_ld = 1'b0;
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
    end else begin
      d     = (n / R) % 4;
      pre   = m_snap >> (4 * (3 - d));
      e_seg = DEC[pre[3:0]];
      e_dp  = !m_dpm[3 - d];
      m_on  = (n > 0) && !blank;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      if (pre == 16'h0 && d != 3) m_on = 1'b0;
`endif
      e_an  = m_on ? (4'hF ^ (4'h1 << (3 - d))) : 4'hF;
      e_fd  = m_ld;
      m_ld  = (n == 0) || (n % (4 * R) == 4 * R - 1);
      if (m_ld) begin
        m_snap = display;
        m_dpm  = dp_mask;
      end
      n++;
    end
    mvalid = 1'b1;
  end

  always @(negedge clk) begin
    if (mvalid) begin
      chk("an", {12'h0, an}, {12'h0, e_an});
      chk("seg", {9'h0, seg}, {9'h0, e_seg});
      chk("dp", {15'h0, dp}, {15'h0, e_dp});
      chk("frame_done", {15'h0, frame_done}, {15'h0, e_fd});
    end
  end

  task automatic hand(input string name, input logic [3:0] xa, input logic [6:0] xs);
    chk({name, "_an"}, {12'h0, an}, {12'h0, xa});
    chk({name, "_seg"}, {9'h0, seg}, {9'h0, xs});
  endtask

  initial begin
    rst = 1'b1; display = 16'h0; dp_mask = 4'h0; blank = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    hand("reset", 4'b1111, 7'b1111111);
    chk("reset_fd", {15'h0, frame_done}, 16'h0);
    rst = 1'b0; display = 16'h1234;
    for (int k = 0; k <= 73; k++) begin
      @(negedge clk);
      case (k)
        0:  begin hand("pre_load", 4'b1111, 7'b1000000);
                  chk("fd0", {15'h0, frame_done}, 16'h0); end
        1:  begin hand("dig0", 4'b0111, 7'b1111001);
                  chk("fd1", {15'h0, frame_done}, 16'h1); end
        2:  chk("fd2", {15'h0, frame_done}, 16'h0);
        4:  hand("dig1", 4'b1011, 7'b0100100);
        7:  hand("dig1_hold", 4'b1011, 7'b0100100);
        8:  hand("dig2", 4'b1101, 7'b0110000);
        12: hand("dig3", 4'b1110, 7'b0011001);
        16: begin hand("frame2", 4'b0111, 7'b1111001);
                  chk("fd16", {15'h0, frame_done}, 16'h1); end
        24: hand("no_tear", 4'b1101, 7'b0110000);
        32: begin hand("new_frame", 4'b0111, 7'b0001000);
                  chk("fd32", {15'h0, frame_done}, 16'h1); end
        52: begin hand("dp_on", 4'b1011, 7'b0000000);
                  chk("dp52", {15'h0, dp}, 16'h0); end
        56: chk("dp56", {15'h0, dp}, 16'h1);
        59: hand("blanked", 4'b1111, 7'b0000000);
        69: hand("unblank", 4'b1011, 7'b0000000);
        default: ;
      endcase
      case (k)
        20: display = 16'hABCD;
        33: begin display = 16'h8888; dp_mask = 4'b0101; end
        58: blank = 1'b1;
        68: blank = 1'b0;
        73: rst = 1'b1;
        default: ;
      endcase
    end
    @(negedge clk);
    hand("mid_rst", 4'b1111, 7'b1111111);
    chk("mid_rst_fd", {15'h0, frame_done}, 16'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    hand("restart", 4'b0111, 7'b0000000);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    display = 16'h0000;
    repeat (40) @(negedge clk);
`endif
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0)
        display = $urandom_range(0, 1) ? 16'($urandom) : 16'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) dp_mask = 4'($urandom);
      if ($urandom_range(0, 15) == 0) blank = ~blank;
      rst = ($urandom_range(0, 199) == 0);
    end
    rst = 1'b0; blank = 1'b0;
    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
